// File: rtl/data_memory_lsu.sv
// Data memory with integrated RV32I load/store unit, valid/ready request and one-cycle response.
// Optional saturating perf counters (perf_loads/stores/faults) when DMEM_PERF_COUNTERS_EN is defined.
module data_memory_lsu #(
    parameter int          DEPTH_WORDS  = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] init_values [0:DEPTH_WORDS-1],
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_check   [0:DEPTH_WORDS-1]
`ifdef DMEM_PERF_COUNTERS_EN
    ,
    output logic [15:0] perf_loads,
    output logic [15:0] perf_stores,
    output logic [15:0] perf_faults
`endif
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic          lat_write, lat_fault;
    logic [2:0]    lat_f3;
    logic [1:0]    lat_lane;
    logic [IW-1:0] lat_idx;

    // Request decode; BASE_ADDR is word aligned so offset[1:0] == req_addr[1:0].
    logic [31:0]   offset;
    logic [IW-1:0] idx;
    logic          out_of_range, illegal, misaligned, req_fault, accept;
    logic [31:0]   wmask, wshift, rd_word, rd_shift;

    assign offset       = req_addr - BASE_ADDR;
    assign idx          = offset[IW+1:2];
    assign out_of_range = {2'b00, offset[31:2]} >= 32'(DEPTH_WORDS);
    assign illegal      = req_write ? (req_funct3 > 3'd2)
                                    : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign misaligned   = (req_funct3[1:0] == 2'b01 && offset[0]) ||
                          (req_funct3[1:0] == 2'b10 && offset[1:0] != 2'b00);
    assign req_fault    = out_of_range | illegal | misaligned;
    assign accept       = req_valid && req_ready;

    always_comb begin
        wmask  = 32'hFFFF_FFFF;
        wshift = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wmask  = 32'h0000_00FF << {offset[1:0], 3'b000};
                wshift = {24'b0, req_wdata[7:0]} << {offset[1:0], 3'b000};
            end
            2'b01: begin
                wmask  = 32'h0000_FFFF << {offset[1], 4'b0000};
                wshift = {16'b0, req_wdata[15:0]} << {offset[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Stores commit on the accepting edge; reset reloads the initial image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= init_values[i];
        end else if (accept && req_write && !req_fault) begin
            mem[idx] <= (mem[idx] & ~wmask) | (wshift & wmask);
        end
    end

    assign mem_check = mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_fault <= 1'b0;
            lat_f3    <= 3'b000;
            lat_lane  <= 2'b00;
            lat_idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_write <= req_write;
                lat_fault <= req_fault;
                lat_f3    <= req_funct3;
                lat_lane  <= offset[1:0];
                lat_idx   <= req_fault ? '0 : idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: if (accept) begin
                state_nxt = (READ_LATENCY > 1) ? S_WAIT : S_RESP;
                cnt_nxt   = WAIT_INIT;
            end
            S_WAIT: begin
                if (cnt == '0) state_nxt = S_RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load data is extracted in RESP; storage is frozen while a request is outstanding.
    always_comb begin
        req_ready  = (state == S_IDLE) && !reset;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_fault = 1'b0;
        rd_word    = mem[lat_idx];
        rd_shift   = rd_word >> {lat_lane, 3'b000};
        if (state == S_RESP && !reset) begin
            resp_valid = 1'b1;
            resp_fault = lat_fault;
            if (!lat_fault && !lat_write) begin
                case (lat_f3)
                    3'b000:  resp_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
                    3'b001:  resp_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
                    3'b100:  resp_rdata = {24'b0, rd_shift[7:0]};
                    3'b101:  resp_rdata = {16'b0, rd_shift[15:0]};
                    default: resp_rdata = rd_word;
                endcase
            end
        end
    end

`ifdef DMEM_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads  <= 16'h0;
            perf_stores <= 16'h0;
            perf_faults <= 16'h0;
        end else if (state == S_RESP) begin
            if (lat_fault) begin
                if (perf_faults != 16'hFFFF) perf_faults <= perf_faults + 1'b1;
            end else if (lat_write) begin
                if (perf_stores != 16'hFFFF) perf_stores <= perf_stores + 1'b1;
            end else begin
                if (perf_loads != 16'hFFFF) perf_loads <= perf_loads + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
// Randomized self-checking bench for data_memory_lsu: two instances (latency 1 / base 0,
// latency 3 / base 0x1000) checked against a byte-level reference model.
module tb_data_memory_lsu;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] init_vals [0:DW-1];
    logic        req_valid [2], req_write [2], req_ready [2], resp_valid [2], resp_fault [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];
    logic [31:0] mc0 [0:DW-1];
    logic [31:0] mc1 [0:DW-1];

    int          n_chk = 0, n_fail = 0;
    logic [31:0] model [2][DW];
    int          lat [2];
    logic [31:0] base [2];
    logic [31:0] last_rdata;
    logic        last_fault;
    longint      last_acc;

    data_memory_lsu #(.DEPTH_WORDS(DW), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .init_values(init_vals),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .mem_check(mc0)
    );

    data_memory_lsu #(.DEPTH_WORDS(DW), .BASE_ADDR(32'h1000), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .init_values(init_vals),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .mem_check(mc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mcw(input int d, input int i);
        return (d == 0) ? mc0[i] : mc1[i];
    endfunction

    // Reference: byte-addressed view of memory, sizes 1/2/4, arithmetic sign extension.
    task automatic model_access(input int d, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic flt, output logic [31:0] rd);
        logic [31:0] off, w;
        longint      idx;
        int          n, lane;
        bit          illegal, mis;
        off     = addr - base[d];
        idx     = longint'(off) / 4;
        n       = 1 << f3[1:0];
        lane    = int'(addr[1:0]);
        illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (n == 2 && lane % 2 != 0) || (n == 4 && lane != 0);
        flt     = (idx >= DW) || illegal || mis;
        rd      = 32'h0;
        if (!flt) begin
            w = model[d][idx];
            if (wr) begin
                for (int i = 0; i < n; i++) w[(lane + i) * 8 +: 8] = wdata[i * 8 +: 8];
                model[d][idx] = w;
            end else begin
                rd = w >> (lane * 8);
                if (n == 1) begin
                    rd = rd % 256;
                    if (!f3[2] && rd >= 128) rd = rd - 256;
                end else if (n == 2) begin
                    rd = rd % 65536;
                    if (!f3[2] && rd >= 32768) rd = rd - 65536;
                end
            end
        end
    endtask

    task automatic issue(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        logic        ef;
        logic [31:0] er;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready[d]), 1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk);
        last_acc = longint'($time);
        model_access(d, wr, f3, addr, wdata, ef, er);
        for (int k = 1; k <= lat[d]; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) req_valid[d] = 1'b0;
                for (int i = 0; i < DW; i++) chk("mem_check", mcw(d, i), model[d][i]);
            end
            chk("busy_ready", 32'(req_ready[d]), 0);
            if (k < lat[d]) begin
                chk("resp_early", 32'(resp_valid[d]), 0);
                chk("rdata_idle", resp_rdata[d], 0);
                chk("fault_idle", 32'(resp_fault[d]), 0);
            end else begin
                chk("resp_valid", 32'(resp_valid[d]), 1);
                chk("resp_rdata", resp_rdata[d], er);
                chk("resp_fault", 32'(resp_fault[d]), 32'(ef));
                last_rdata = resp_rdata[d];
                last_fault = resp_fault[d];
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint      t1;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        wr;
        bit          hold;
        lat[0] = 1; lat[1] = 3;
        base[0] = 32'h0; base[1] = 32'h1000;
        for (int i = 0; i < DW; i++) init_vals[i] = $urandom;
        init_vals[1] = 32'h8081_82F3;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
            for (int i = 0; i < DW; i++) model[d][i] = init_vals[i];
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 0);
            chk("rst_resp_valid", 32'(resp_valid[d]), 0);
            chk("rst_rdata", resp_rdata[d], 0);
            chk("rst_fault", 32'(resp_fault[d]), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_ready", 32'(req_ready[d]), 1);
            for (int i = 0; i < DW; i++) chk("init_mem", mcw(d, i), init_vals[i]);
        end

        // Basic and sub-word loads, byte-lane stores, faults (latency 1, base 0)
        issue(0, 0, 3'b010, 32'd4, 32'h0, 0); chk("lw4", last_rdata, 32'h8081_82F3);
        chk("lw4_fault", 32'(last_fault), 0);
        issue(0, 0, 3'b000, 32'd4, 32'h0, 0); chk("lb4", last_rdata, 32'hFFFF_FFF3);
        issue(0, 0, 3'b100, 32'd5, 32'h0, 0); chk("lbu5", last_rdata, 32'h0000_0082);
        issue(0, 0, 3'b001, 32'd6, 32'h0, 0); chk("lh6", last_rdata, 32'hFFFF_8081);
        issue(0, 0, 3'b101, 32'd6, 32'h0, 0); chk("lhu6", last_rdata, 32'h0000_8081);
        issue(0, 1, 3'b000, 32'd5, 32'hDEAD_BEAA, 0);
        chk("sb5_mem", mc0[1], 32'h8081_AAF3); chk("sb5_rdata", last_rdata, 0);
        issue(0, 1, 3'b001, 32'd6, 32'h0000_1234, 0);
        chk("sh6_mem", mc0[1], 32'h1234_AAF3); chk("sh6_rdata", last_rdata, 0);
        issue(0, 0, 3'b010, 32'd6, 32'h0, 0);
        chk("lw6_mis_fault", 32'(last_fault), 1); chk("lw6_mis_rdata", last_rdata, 0);
        issue(0, 1, 3'b010, 32'd128, 32'h1111_2222, 0); chk("sw128_oor", 32'(last_fault), 1);
        issue(0, 0, 3'b011, 32'd0, 32'h0, 0); chk("ld_f3_011", 32'(last_fault), 1);

        // Base 0x1000, latency 3
        issue(1, 0, 3'b010, 32'd0, 32'h0, 0); chk("below_base", 32'(last_fault), 1);
        issue(1, 0, 3'b010, 32'h1004, 32'h0, 1);
        chk("lat3_lw", last_rdata, 32'h8081_82F3);
        t1 = last_acc;
        issue(1, 0, 3'b010, 32'h1008, 32'h0, 0);
        chk("b2b_gap", 32'(last_acc - t1), 40);

        // Random traffic against the model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                wr = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 9))
                    0, 1, 2: f3 = 3'b000;
                    3, 4:    f3 = 3'b001;
                    5, 6:    f3 = 3'b010;
                    7:       f3 = wr ? 3'b010 : 3'b100;
                    8:       f3 = wr ? 3'b000 : 3'b101;
                    default: f3 = 3'($urandom_range(0, 7));
                endcase
                case ($urandom_range(0, 9))
                    8:       addr = base[d] - 32'($urandom_range(1, 8));
                    9:       addr = $urandom;
                    default: addr = base[d] + 32'($urandom_range(0, DW * 4 + 7));
                endcase
                hold = (n != 79) && ($urandom_range(0, 3) == 0);
                issue(d, wr, f3, addr, $urandom, hold);
                if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Reset mid-operation in WAIT after a store changed word 0
        issue(1, 1, 3'b010, 32'h1000, 32'hCAFE_F00D, 0);
        chk("sw0_mem", mc1[0], 32'hCAFE_F00D);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h1004;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready_now", 32'(req_ready[1]), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_mid_resp", 32'(resp_valid[d]), 0);
                chk("rst_mid_ready", 32'(req_ready[d]), 0);
            end
        end
        chk("rst_mid_mem0", mc1[0], init_vals[0]);
        chk("rst_mid_mem1_l1", mc0[1], init_vals[1]);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DW; i++) model[d][i] = init_vals[i];
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", 32'(req_ready[1]), 1);
        chk("rst_rel_resp", 32'(resp_valid[1]), 0);
        issue(1, 0, 3'b010, 32'h1000, 32'h0, 0); chk("after_rst_lw", last_rdata, init_vals[0]);
        issue(0, 0, 3'b101, 32'd6, 32'h0, 0);   chk("after_rst_lhu", last_rdata, 32'h0000_8081);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
